// File: rtl/dht_pkg.sv
// Shared FSM encoding, frame layout and checksum helper for the DHT polling sequencer.
package dht_pkg;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        TRIG       = 5'b00010,
        WAIT_FRAME = 5'b00100,
        CHECK      = 5'b01000,
        WAIT_POLL  = 5'b10000
    } dht_state_t;

    localparam int unsigned FRAME_W      = 40;
    localparam int unsigned HUM_INT_LSB  = 32;
    localparam int unsigned HUM_DEC_LSB  = 24;
    localparam int unsigned TEMP_INT_LSB = 16;
    localparam int unsigned TEMP_DEC_LSB = 8;
    localparam int unsigned CSUM_LSB     = 0;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    // Checksum is the mod-256 sum of the four data bytes.
    function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
        logic [7:0] sum;
        sum = f[HUM_INT_LSB +: 8] + f[HUM_DEC_LSB +: 8]
            + f[TEMP_INT_LSB +: 8] + f[TEMP_DEC_LSB +: 8];
        return sum == f[CSUM_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht_sat_cntr.sv
// 8-bit event counter that sticks at its maximum value.
module dht_sat_cntr
    import dht_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'h00;
        end else if (inc && (cnt != SAT_MAX)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dht_poll_ctrl.sv
// Periodic DHT poll sequencer: start, await frame with timeout, checksum, retry, publish.
// Error counters exist only when DHT_POLL_STATS_EN is defined; otherwise they read zero.
module dht_poll_ctrl
    import dht_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = 200000000,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned RETRY_CYCLES   = 10000000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_W          = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_ready,
    input  logic [FRAME_W-1:0] frame,
    output logic               sensor_start,
    output logic [7:0]         hum_int,
    output logic [7:0]         hum_dec,
    output logic [7:0]         temp_int,
    output logic [7:0]         temp_dec,
    output logic               data_valid,
    output logic               update,
    output logic               busy,
    output logic               fail,
    output logic [7:0]         crc_err_cnt,
    output logic [7:0]         timeout_cnt
);

    localparam int unsigned RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST    = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST   = CNT_W'(RETRY_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRY);

    dht_state_t         state;
    logic [CNT_W-1:0]   timer;
    logic [RC_W-1:0]    retry_cnt;
    logic [FRAME_W-1:0] shadow;
    logic               gap_long;
    logic               timeout_c;
    logic               crc_bad_c;

    // A frame arriving on the last wait cycle takes priority over the timeout.
    assign timeout_c = enable && (state == WAIT_FRAME) && !frame_ready && (timer == TIMEOUT_LAST);
    assign crc_bad_c = enable && (state == CHECK) && !frame_ok(shadow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            retry_cnt    <= '0;
            shadow       <= '0;
            gap_long     <= 1'b0;
            sensor_start <= 1'b0;
            hum_int      <= 8'h00;
            hum_dec      <= 8'h00;
            temp_int     <= 8'h00;
            temp_dec     <= 8'h00;
            data_valid   <= 1'b0;
            update       <= 1'b0;
            busy         <= 1'b0;
            fail         <= 1'b0;
        end else begin
            sensor_start <= 1'b0;
            update       <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                busy      <= 1'b0;
                timer     <= '0;
                retry_cnt <= '0;
            end else if (timeout_c || crc_bad_c) begin
                // Failed attempt: short retry gap until retries run out, then flag and back off.
                state <= WAIT_POLL;
                busy  <= 1'b0;
                timer <= '0;
                if (retry_cnt < RETRY_MAX) begin
                    retry_cnt <= retry_cnt + RC_W'(1);
                    gap_long  <= 1'b0;
                end else begin
                    fail      <= 1'b1;
                    retry_cnt <= '0;
                    gap_long  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        timer        <= '0;
                        retry_cnt    <= '0;
                        state        <= TRIG;
                        busy         <= 1'b1;
                        sensor_start <= 1'b1;
                    end
                    TRIG: begin
                        timer <= '0;
                        state <= WAIT_FRAME;
                    end
                    WAIT_FRAME: begin
                        if (frame_ready) begin
                            shadow <= frame;
                            state  <= CHECK;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        hum_int    <= shadow[HUM_INT_LSB +: 8];
                        hum_dec    <= shadow[HUM_DEC_LSB +: 8];
                        temp_int   <= shadow[TEMP_INT_LSB +: 8];
                        temp_dec   <= shadow[TEMP_DEC_LSB +: 8];
                        update     <= 1'b1;
                        data_valid <= 1'b1;
                        fail       <= 1'b0;
                        retry_cnt  <= '0;
                        gap_long   <= 1'b1;
                        timer      <= '0;
                        busy       <= 1'b0;
                        state      <= WAIT_POLL;
                    end
                    WAIT_POLL: begin
                        if (timer == (gap_long ? POLL_LAST : RETRY_LAST)) begin
                            timer        <= '0;
                            state        <= TRIG;
                            busy         <= 1'b1;
                            sensor_start <= 1'b1;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DHT_POLL_STATS_EN
    dht_sat_cntr u_crc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (crc_bad_c),
        .cnt (crc_err_cnt)
    );

    dht_sat_cntr u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .inc (timeout_c),
        .cnt (timeout_cnt)
    );
`else
    assign crc_err_cnt = 8'h00;
    assign timeout_cnt = 8'h00;
`endif

endmodule
